// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencing for load-use, shared-memory and branch hazards.
module hazard_ctrl #(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [3:0]       IdReadIndex1,
  input  logic [3:0]       IdReadIndex2,
  input  logic             IdUses1,
  input  logic             IdUses2,
  input  logic             ExMemRead,
  input  logic [3:0]       ExRegWriteIndex,
  input  logic             MemAccess,
  input  logic             BranchTaken,
  output logic             PcHold,
  output logic             IfIdHold,
  output logic             IfIdFlush,
  output logic             IdExPause,
  output logic             IdExFlush,
  output logic             Busy,
  output logic [CNT_W-1:0] StallCnt
);
  typedef enum logic [1:0] {S_RUN, S_REPLAY, S_WAIT} state_t;
  // Deferred wait (after a branch) holds all MEM_WAIT cycles in S_WAIT; a direct one spends its first in RUN.
  localparam logic [3:0] WAIT_FULL = 4'(MEM_WAIT);
  localparam logic [3:0] WAIT_RUN  = 4'(MEM_WAIT - 1);
  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q;
  logic lu, pc_hold, ifid_hold, ifid_flush, pause, idex_flush;
  assign lu = ExMemRead & ((IdUses1 & (IdReadIndex1 == ExRegWriteIndex)) |
                           (IdUses2 & (IdReadIndex2 == ExRegWriteIndex)));
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    pause      = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      S_WAIT: begin
        pc_hold    = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = BranchTaken;
        wait_d     = wait_q - 4'd1;
        state_d    = (wait_q <= 4'd1) ? S_RUN : S_WAIT;
      end
      default: begin
        state_d = S_RUN;
        if (BranchTaken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (MemAccess) begin
            state_d = S_WAIT;
            wait_d  = WAIT_FULL;
          end
        end else if (MemAccess) begin
          pc_hold    = 1'b1;
          ifid_flush = 1'b1;
          wait_d     = WAIT_RUN;
          state_d    = (MEM_WAIT > 1) ? S_WAIT : S_RUN;
        end else if (lu && state_q == S_RUN) begin
          pause     = 1'b1;
          pc_hold   = 1'b1;
          ifid_hold = 1'b1;
          state_d   = S_REPLAY;
        end
      end
    endcase
  end
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_RUN;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (PcHold && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end
  assign PcHold    = Rst & pc_hold;
  assign IfIdHold  = Rst & ifid_hold;
  assign IfIdFlush = Rst & ifid_flush;
  assign IdExPause = Rst & pause;
  assign IdExFlush = Rst & idex_flush;
  assign Busy      = Rst & (state_q != S_RUN);
  assign StallCnt  = cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a cycle-count model.
module tb_hazard_ctrl;
  localparam int MW = 2;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic [3:0] r1 = '0, r2 = '0, wd = '0;
  logic u1 = 1'b0, u2 = 1'b0, exrd = 1'b0, mem = 1'b0, br = 1'b0;
  logic pc_hold, ifid_hold, ifid_flush, idex_pause, idex_flush, busy;
  logic [15:0] stall_cnt;
  logic s_mem = 1'b0;
  logic s_pc, s_ifh, s_iff, s_pause, s_idf, s_busy;
  logic [3:0] s_cnt;
  int n_pass = 0, n_tot = 0;
  int m_left = 0;
  bit m_plast = 1'b0;
  int m_cnt = 0;

  always #5 Clk = ~Clk;

  hazard_ctrl #(.MEM_WAIT(MW), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .IdReadIndex1(r1), .IdReadIndex2(r2), .IdUses1(u1), .IdUses2(u2),
    .ExMemRead(exrd), .ExRegWriteIndex(wd), .MemAccess(mem), .BranchTaken(br),
    .PcHold(pc_hold), .IfIdHold(ifid_hold), .IfIdFlush(ifid_flush), .IdExPause(idex_pause),
    .IdExFlush(idex_flush), .Busy(busy), .StallCnt(stall_cnt));

  hazard_ctrl #(.MEM_WAIT(1), .CNT_W(4)) u_sat (
    .Clk(Clk), .Rst(Rst), .IdReadIndex1(4'd0), .IdReadIndex2(4'd0), .IdUses1(1'b0), .IdUses2(1'b0),
    .ExMemRead(1'b0), .ExRegWriteIndex(4'd0), .MemAccess(s_mem), .BranchTaken(1'b0),
    .PcHold(s_pc), .IfIdHold(s_ifh), .IfIdFlush(s_iff), .IdExPause(s_pause),
    .IdExFlush(s_idf), .Busy(s_busy), .StallCnt(s_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] dut_vec();
    return {pc_hold, ifid_hold, ifid_flush, idex_pause, idex_flush, busy};
  endfunction

  // Order {PcHold, IfIdHold, IfIdFlush, IdExPause, IdExFlush, Busy}.
  function automatic logic [5:0] model_out();
    bit lu;
    lu = exrd && ((u1 && r1 == wd) || (u2 && r2 == wd));
    if (m_left > 0) return {1'b1, 1'b0, 1'b1, 1'b0, br, 1'b1};
    if (br) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, m_plast};
    if (mem) return {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_plast};
    if (lu && !m_plast) return 6'b110100;
    return {5'b0, m_plast};
  endfunction

  task automatic model_step();
    logic [5:0] o;
    o = model_out();
    if (o[5] && m_cnt < 65535) m_cnt++;
    if (m_left > 0) m_left--;
    else if (br) begin
      m_left = mem ? MW : 0;
      m_plast = 1'b0;
    end else if (mem) begin
      m_left = MW - 1;
      m_plast = 1'b0;
    end else m_plast = o[2];
  endtask

  task automatic tick(input string tag, input bit dchk, input logic [5:0] dexp);
    #1;
    chk({tag, "_ctl"}, 32'(dut_vec()), 32'(model_out()));
    chk({tag, "_cnt"}, 32'(stall_cnt), 32'(m_cnt));
    if (dchk) chk({tag, "_dir"}, 32'(dut_vec()), 32'(dexp));
    model_step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic ua, input logic ub,
                        input logic ld, input logic [3:0] w, input logic m, input logic bt);
    r1 = a; r2 = b; u1 = ua; u2 = ub; exrd = ld; wd = w; mem = m; br = bt;
  endtask

  initial begin
    set_in(4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
    #2;
    chk("rst_ctl", 32'(dut_vec()), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    set_in(4'd3, 4'd0, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    tick("lu0", 1'b1, 6'b110100);
    tick("lu1", 1'b1, 6'b000001);
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick("lu2", 1'b1, 6'b000000);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    set_in(4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0);
    tick("nouse", 1'b1, 6'b000000);
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick("mem0", 1'b1, 6'b101000);
    mem = 1'b0;
    tick("mem1", 1'b1, 6'b101001);
    tick("mem2", 1'b1, 6'b000000);
    chk("mem_cnt", 32'(stall_cnt), 32'd3);
    set_in(4'd5, 4'd0, 1'b1, 1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    tick("all0", 1'b1, 6'b001010);
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick("all1", 1'b1, 6'b101001);
    tick("all2", 1'b1, 6'b101001);
    tick("all3", 1'b1, 6'b000000);
    set_in(4'd0, 4'd7, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick("lu_run", 1'b1, (i % 2 == 0) ? 6'b110100 : 6'b000001);
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick("idle", 1'b1, 6'b000000);
    s_mem = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("sat_ctl", 32'({s_pc, s_ifh, s_iff, s_pause, s_idf, s_busy}), 32'(6'b101000));
      chk("sat_cnt", 32'(s_cnt), 32'((i < 15) ? i : 15));
      tick("sat_idle", 1'b0, 6'b0);
    end
    s_mem = 1'b0;
    #1;
    chk("sat_end", 32'(s_cnt), 32'd15);
    for (int i = 0; i < 400; i++) begin
      set_in(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
             1'($urandom), 4'($urandom_range(0, 3)), ($urandom % 6) == 0, ($urandom % 6) == 0);
      tick("rnd", 1'b0, 6'b0);
    end
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick("rm0", 1'b1, 6'b101000);
    mem = 1'b0;
    #1;
    chk("rm_busy", 32'(busy), 32'd1);
    #1;
    Rst = 1'b0;
    #1;
    chk("rm_ctl", 32'(dut_vec()), 32'd0);
    chk("rm_cnt", 32'(stall_cnt), 32'd0);
    set_in(4'd2, 4'd0, 1'b1, 1'b0, 1'b1, 4'd2, 1'b1, 1'b1);
    #1;
    chk("rm_force", 32'(dut_vec()), 32'd0);
    @(negedge Clk);
    Rst = 1'b1;
    m_left = 0;
    m_plast = 1'b0;
    m_cnt = 0;
    set_in(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick("post_rst", 1'b1, 6'b000000);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller; drives the stall/flush controls consumed by the PC register, the IF/ID register and the ID/EX register.
- Detects three conditions and drives a hold, bubble, replay or flush sequence for each:
  - load-use data hazards;
  - shared-memory structural hazards (data access in MEM blocks instruction fetch);
  - taken branches and jumps.
- Sits beside the ID stage. Its Pause pulse feeds the ID/EX register, which inserts a bubble and replays the captured instruction on the following cycle.

Parameters:
- MEM_WAIT, 2, cycles instruction fetch is blocked per MEM-stage data access (1..15)
- CNT_W, 16, width of the saturating stall statistics counter

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, asynchronous, active-low
- IdReadIndex1  in  4  ID-stage source register 1 index
- IdReadIndex2  in  4  ID-stage source register 2 index
- IdUses1  in  1  ID instruction actually reads source 1
- IdUses2  in  1  ID instruction actually reads source 2
- ExMemRead  in  1  EX-stage instruction is a load (ID/EX MemRead1)
- ExRegWriteIndex  in  4  EX-stage destination (ID/EX RegWriteIndex1)
- MemAccess  in  1  MEM-stage instruction uses the shared RAM
- BranchTaken  in  1  EX resolved a taken branch or jump
- PcHold  out  1  PC keeps its value
- IfIdHold  out  1  IF/ID keeps its value
- IfIdFlush  out  1  IF/ID loads a bubble
- IdExPause  out  1  to ID/EX Pause: bubble now, replay next cycle
- IdExFlush  out  1  ID/EX loads a bubble with no replay
- Busy  out  1  state is not RUN
- StallCnt  out  CNT_W  cycles spent with PcHold=1, saturating

Behaviour:
- States: RUN, REPLAY, MEM_WAIT.
  - The state register, the wait counter (4 bits) and StallCnt are sequential.
  - All control outputs are combinational from state and inputs.
- Reset (Rst=0, asynchronous):
  - state=RUN, wait counter=0, StallCnt=0.
  - All control outputs and Busy forced to 0 while Rst=0, regardless of inputs.
- Load-use condition LU: ExMemRead & ((IdUses1 & IdReadIndex1==ExRegWriteIndex) | (IdUses2 & IdReadIndex2==ExRegWriteIndex)).
  - Index 0 is not special; a match on r0 still stalls.
- Priority, highest first: BranchTaken > MemAccess > LU.
- RUN:
  - BranchTaken: IfIdFlush=1 and IdExFlush=1 for this cycle; stay in RUN.
    - BranchTaken overrides a simultaneous LU: no pause is issued.
    - A simultaneous MemAccess is still honoured next cycle.
  - MemAccess (no branch):
    - PcHold=1, IfIdFlush=1.
    - Load the wait counter with MEM_WAIT-1, go to MEM_WAIT.
    - If MEM_WAIT=1, stay in RUN instead (single-cycle block).
  - LU (no branch, no MemAccess): IdExPause=1, PcHold=1, IfIdHold=1; go to REPLAY.
  - Otherwise: all outputs 0.
- REPLAY: exactly one cycle; ID/EX is replaying the captured instruction.
  - IdExPause=0 always; Pause is never asserted on two consecutive cycles.
  - PcHold=0 and IfIdHold=0, so IF/ID advances to the next instruction.
  - LU is ignored this cycle, because the ID input is discarded by ID/EX.
  - BranchTaken: IfIdFlush=1, IdExFlush=1; go to RUN.
  - MemAccess: handled as in RUN, entering MEM_WAIT.
  - Otherwise go to RUN.
- MEM_WAIT:
  - PcHold=1, IfIdFlush=1 every cycle; the counter decrements each cycle.
  - At counter==0, return to RUN on the next edge.
  - BranchTaken during MEM_WAIT: assert IdExFlush=1 for that cycle. The wait continues, because the PC redirect is owned by the PC mux.
  - A new MemAccess while the counter is nonzero is ignored; only the instruction in MEM is counted.
- StallCnt: increments on each edge where PcHold=1; saturates at all-ones and never wraps.
- Busy = (state != RUN).
- Rst deasserting mid-sequence: the state machine restarts in RUN; no pending pause or wait survives reset.

Test Plan:
- Load r3 in EX (ExMemRead=1, ExRegWriteIndex=3), ID reads r3 via source 1 ->
  - cycle 0: IdExPause=1, PcHold=1, IfIdHold=1;
  - cycle 1: all outputs 0, Busy=1;
  - cycle 2: RUN, StallCnt=1.
- Same as above but IdUses1=0 with an index match -> no pause; all outputs 0.
- MemAccess=1 for one cycle with MEM_WAIT=2 -> PcHold and IfIdFlush high for exactly 2 cycles, then RUN; StallCnt=2.
- LU, MemAccess and BranchTaken asserted in the same cycle ->
  - IfIdFlush=1, IdExFlush=1, IdExPause=0;
  - next cycle PcHold=1 (memory wait begins).
- LU held continuously for 4 cycles -> IdExPause pattern 1,0,1,0; never two consecutive 1s.
- StallCnt preloaded near saturation with CNT_W=4, 20 stall cycles -> StallCnt sticks at 15.
- Rst pulsed low during MEM_WAIT -> outputs 0 immediately (asynchronous), state RUN after release, StallCnt=0.
